// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared CPU constants: data width and register-transfer opcodes
package reg_file_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [2:0] OP_LOAD_R0   = 3'b000;
    localparam logic [2:0] OP_LOAD_R1   = 3'b001;
    localparam logic [2:0] OP_MOV_R1_R0 = 3'b010;
    localparam logic [2:0] OP_MOV_R0_R1 = 3'b011;
    // Decoder idle opcode; 3'b100..3'b110 also decode as NOP.
    localparam logic [2:0] OP_NOP       = 3'b111;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-entry register file (R0, R1) executing one transfer opcode per clock
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ena,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] R0_out,
    output logic [WIDTH-1:0] R1_out
);

    logic [WIDTH-1:0] r0_q, r0_d;
    logic [WIDTH-1:0] r1_q, r1_d;

    // MOVs read the pre-edge register values, so a MOV right after a LOAD sees the loaded data.
    always_comb begin
        r0_d = r0_q;
        r1_d = r1_q;
        if (ena) begin
            case (opcode)
                OP_LOAD_R0:   r0_d = data_in;
                OP_LOAD_R1:   r1_d = data_in;
                OP_MOV_R1_R0: r1_d = r0_q;
                OP_MOV_R0_R1: r0_d = r1_q;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r0_q <= '0;
            r1_q <= '0;
        end else begin
            r0_q <= r0_d;
            r1_q <= r1_d;
        end
    end

    assign R0_out = r0_q;
    assign R1_out = r1_q;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed and randomized bench for reg_file against a two-register array model
module tb_reg_file;

    logic       clock;
    logic       reset;
    logic       ena;
    logic [2:0] opcode;
    logic [7:0] data_in;
    logic [7:0] R0_out;
    logic [7:0] R1_out;

    int checks;
    int errors;
    logic [7:0] model [2];

    reg_file #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .ena     (ena),
        .opcode  (opcode),
        .data_in (data_in),
        .R0_out  (R0_out),
        .R1_out  (R1_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_r0"}, R0_out, model[0]);
        check({tag, "_r1"}, R1_out, model[1]);
    endtask

    // Called at a falling edge; drives one operation, checks after the next rising edge.
    task automatic step(input logic [2:0] op, input logic [7:0] d, input logic en, input string tag);
        logic [7:0] old0, old1;
        opcode  = op;
        data_in = d;
        ena     = en;
        @(posedge clock);
        old0 = model[0];
        old1 = model[1];
        if (en && reset) begin
            if (op == 3'd0) model[0] = d;
            else if (op == 3'd1) model[1] = d;
            else if (op == 3'd2) model[1] = old0;
            else if (op == 3'd3) model[0] = old1;
        end
        #1;
        check_both(tag);
        @(negedge clock);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        model[0] = 8'd0;
        model[1] = 8'd0;
        reset    = 1'b0;
        ena      = 1'b0;
        opcode   = 3'b111;
        data_in  = 8'd0;

        repeat (5) @(posedge clock);
        #1;
        check_both("reset_hold");
        @(negedge clock);
        reset = 1'b1;
        step(3'b111, 8'd0, 1'b0, "reset_release");

        step(3'b000, 8'd25,  1'b1, "load_r0_25");
        step(3'b000, 8'd100, 1'b1, "load_r0_100");
        step(3'b001, 8'd50,  1'b1, "load_r1_50");
        step(3'b001, 8'd200, 1'b1, "load_r1_200");

        step(3'b000, 8'd77, 1'b1, "load_r0_77");
        step(3'b010, 8'd0,  1'b1, "mov_r1_r0");
        check("mov_r1_r0_abs", R1_out, 8'd77);
        step(3'b001, 8'd88, 1'b1, "load_r1_88");
        step(3'b011, 8'd0,  1'b1, "mov_r0_r1");
        check("mov_r0_r1_abs", R0_out, 8'd88);

        step(3'b111, 8'd255, 1'b1, "nop_111");
        for (int op = 4; op < 7; op++) step(3'(op), 8'd255, 1'b1, "nop_1xx");

        step(3'b000, 8'd15, 1'b1, "load_r0_15");
        step(3'b001, 8'd30, 1'b1, "load_r1_30");
        step(3'b000, 8'd45, 1'b1, "load_r0_45");
        step(3'b000, 8'd99, 1'b0, "ena_low_hold");
        check("ena_low_r0_abs", R0_out, 8'd45);
        step(3'b000, 8'd99, 1'b1, "ena_high_load");
        check("ena_high_r0_abs", R0_out, 8'd99);

        step(3'b000, 8'hFF, 1'b1, "load_r0_max");
        step(3'b001, 8'h80, 1'b1, "load_r1_msb");

        // Asynchronous reset mid-cycle with a LOAD pending.
        opcode  = 3'b000;
        data_in = 8'h55;
        ena     = 1'b1;
        #2;
        reset    = 1'b0;
        model[0] = 8'd0;
        model[1] = 8'd0;
        #1;
        check_both("async_reset");
        @(posedge clock);
        #1;
        check_both("reset_edge_discard");
        @(negedge clock);
        reset = 1'b1;
        step(3'b111, 8'h55, 1'b1, "post_reset_nop");
        step(3'b010, 8'h55, 1'b1, "post_reset_mov");
        step(3'b001, 8'h3C, 1'b1, "post_reset_load");

        for (int i = 0; i < 300; i++) begin
            step(3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 4) != 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
